// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Single-port word memory behind a valid/ready request channel and a
// valid/ready response channel. Each accepted request is answered after a
// fixed LATENCY. Only one transaction is in flight at a time.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   The responder holds rsp_valid/rsp_rdata/rsp_err stable until the
//   initiator takes the response. A request is only accepted in IDLE.
//   Request inputs are ignored outside IDLE.
//
// Ports
//   clk_x70        in   sole clock, rising edge
//   rst_x70        in   synchronous active-high reset (memory is not cleared)
//   req_valid_x70  in   request present
//   req_ready_x70  out  1 only in IDLE
//   req_write_x70  in   1 = store, 0 = load
//   req_addr_x70   in   32-bit byte address (must be word aligned and in range)
//   req_wdata_x70  in   store data
//   req_be_x70     in   store byte enables, bit i -> bits [8i+7:8i]
//   rsp_valid_x70  out  response present (state RESP)
//   rsp_ready_x70  in   initiator takes the response
//   rsp_rdata_x70  out  load data (0 for stores and errors)
//   rsp_err_x70    out  misaligned or out-of-range request
//   busy_x70       out  state is not IDLE
//
// The FSM state is held in state_q (state_e) for checker binding.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_x70,
  input  logic        rst_x70,
  input  logic        req_valid_x70,
  output logic        req_ready_x70,
  input  logic        req_write_x70,
  input  logic [31:0] req_addr_x70,
  input  logic [31:0] req_wdata_x70,
  input  logic [3:0]  req_be_x70,
  output logic        rsp_valid_x70,
  input  logic        rsp_ready_x70,
  output logic [31:0] rsp_rdata_x70,
  output logic        rsp_err_x70,
  output logic        busy_x70
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              txn_write;
  logic [31:0]       txn_addr;
  logic [31:0]       txn_wdata;
  logic [3:0]        txn_be;
  logic              txn_err;
  logic [ADDR_W-1:0] txn_idx;
  logic              do_store;

  assign accept = req_valid_x70 && (state_q == IDLE);

  // The array access happens on the edge that enters RESP. With LATENCY=1
  // that is the accept edge itself, so the live request fields are used;
  // otherwise the fields captured at accept are used.
  always_comb begin
    txn_write = write_q;
    txn_addr  = addr_q;
    txn_wdata = wdata_q;
    txn_be    = be_q;
    if (state_q == IDLE) begin
      txn_write = req_write_x70;
      txn_addr  = req_addr_x70;
      txn_wdata = req_wdata_x70;
      txn_be    = req_be_x70;
    end
  end

  // Anything above the word-index bits means out of range; no wrap-around.
  assign txn_err = (txn_addr[1:0] != 2'b00) || ((txn_addr >> (ADDR_W + 2)) != 32'd0);
  assign txn_idx = txn_addr[ADDR_W+1:2];

  // Next-state and response-data logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_x70) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        // The counter reaching 0 on this edge is the transition into RESP.
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_x70) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    enter_resp = (state_d == RESP) && (state_q != RESP);
    if (enter_resp) begin
      err_d   = txn_err;
      rdata_d = (txn_err || txn_write) ? 32'd0 : mem[txn_idx];
    end
  end

  assign do_store = enter_resp && txn_write && !txn_err && !rst_x70;

  // State and transaction registers
  always_ff @(posedge clk_x70) begin
    if (rst_x70) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q <= req_write_x70;
        addr_q  <= req_addr_x70;
        wdata_q <= req_wdata_x70;
        be_q    <= req_be_x70;
      end
    end
  end

  // Memory array: no reset, byte-granular writes.
  always_ff @(posedge clk_x70) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (txn_be[b]) begin
          mem[txn_idx][8*b +: 8] <= txn_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready_x70 = (state_q == IDLE);
  assign rsp_valid_x70 = (state_q == RESP);
  assign busy_x70      = (state_q != IDLE);
  assign rsp_rdata_x70 = rdata_q;
  assign rsp_err_x70   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// Bench for data_mem_responder: main instance (ADDR_W=10, LATENCY=2) driven
// transaction by transaction against a memory model and an expected-response
// queue, plus two instances (LATENCY=1 and 15) run back-to-back to measure
// accept spacing.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int TB_AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  data_mem_responder #(.ADDR_W(TB_AW), .LATENCY(2)) dut (
    .clk_x70       (clk),
    .rst_x70       (rst),
    .req_valid_x70 (req_valid),
    .req_ready_x70 (req_ready),
    .req_write_x70 (req_write),
    .req_addr_x70  (req_addr),
    .req_wdata_x70 (req_wdata),
    .req_be_x70    (req_be),
    .rsp_valid_x70 (rsp_valid),
    .rsp_ready_x70 (rsp_ready),
    .rsp_rdata_x70 (rsp_rdata),
    .rsp_err_x70   (rsp_err),
    .busy_x70      (busy)
  );

  // Latency sweep instances: stores to word 0, response always taken.
  logic        s_rst, s_valid;
  logic [31:0] s_wdata;
  logic        s1_ready, s1_rsp_valid, s1_err, s1_busy;
  logic [31:0] s1_rdata;
  logic        s15_ready, s15_rsp_valid, s15_err, s15_busy;
  logic [31:0] s15_rdata;

  data_mem_responder #(.ADDR_W(TB_AW), .LATENCY(1)) dut_l1 (
    .clk_x70(clk), .rst_x70(s_rst), .req_valid_x70(s_valid), .req_ready_x70(s1_ready),
    .req_write_x70(1'b1), .req_addr_x70(32'h0), .req_wdata_x70(s_wdata), .req_be_x70(4'hF),
    .rsp_valid_x70(s1_rsp_valid), .rsp_ready_x70(1'b1), .rsp_rdata_x70(s1_rdata),
    .rsp_err_x70(s1_err), .busy_x70(s1_busy)
  );

  data_mem_responder #(.ADDR_W(TB_AW), .LATENCY(15)) dut_l15 (
    .clk_x70(clk), .rst_x70(s_rst), .req_valid_x70(s_valid), .req_ready_x70(s15_ready),
    .req_write_x70(1'b1), .req_addr_x70(32'h0), .req_wdata_x70(s_wdata), .req_be_x70(4'hF),
    .rsp_valid_x70(s15_rsp_valid), .rsp_ready_x70(1'b1), .rsp_rdata_x70(s15_rdata),
    .rsp_err_x70(s15_err), .busy_x70(s15_busy)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];          // {err, rdata}
  logic [31:0] model [1 << TB_AW];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Computes the expected response
  // from the model, runs one transaction holding rsp_ready low for `hold`
  // cycles in RESP, and returns the consumed response.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] got_d, output logic got_e);
    int n;
    logic e;
    logic [TB_AW-1:0] idx;
    logic [31:0] exp_d, hd;
    logic [32:0] exp;
    logic he;
    e   = (a[1:0] != 2'b00) || (a[31:TB_AW+2] != '0);
    idx = a[TB_AW+1:2];
    exp_d = (e || wr) ? 32'd0 : model[idx];
    if (!e && wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
    exp_q.push_back({e, exp_d});

    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check_eq("req_ready_timeout", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    // Garbage on the request bus while busy must be ignored.
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);

    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    check_eq("rsp_latency", 64'(n), 64'd2);
    hd = rsp_rdata; he = rsp_err;
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_rdata", 64'(rsp_rdata), 64'(hd));
      check_eq("hold_err", 64'(rsp_err), 64'(he));
      check_eq("hold_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check_eq("exp_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp[31:0]));
    check_eq("rsp_err", 64'(rsp_err), 64'(exp[32]));
    check_eq("consume_req_ready", 64'(req_ready), 64'd0);
    got_d = rsp_rdata; got_e = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_consume_valid", 64'(rsp_valid), 64'd0);
    check_eq("post_consume_ready", 64'(req_ready), 64'd1);
  endtask

  // ---------------- sweep monitor ----------------
  int cyc = 0;
  int s1_last = 0, s15_last = 0, s1_acc = 0, s15_acc = 0;
  always @(negedge clk) begin
    cyc++;
    if (!s_rst && s_valid) begin
      if (s1_ready) begin
        if (s1_acc > 0) check_eq("lat1_spacing", 64'(cyc - s1_last), 64'd2);
        s1_last = cyc; s1_acc++;
      end
      if (s15_ready) begin
        if (s15_acc > 0) check_eq("lat15_spacing", 64'(cyc - s15_last), 64'd16);
        s15_last = cyc; s15_acc++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [31:0] d;
  logic        e;
  int          n;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b0; s_rst = 1'b1; s_valid = 1'b0; s_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("rst_err", 64'(rsp_err), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);

    // Store then load
    send(1'b1, 32'h40, 32'h12345678, 4'hF, 0, d, e);
    send(1'b0, 32'h40, 32'h0, 4'hF, 0, d, e);
    check_eq("load_full_word", 64'(d), 64'h12345678);

    // Partial byte-enable store
    send(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 0, d, e);
    send(1'b0, 32'h40, 32'h0, 4'hF, 0, d, e);
    check_eq("load_be_merge", 64'(d), 64'h12BB56DD);

    // Error cases: misaligned and out of range, loads and stores
    send(1'b0, 32'h42, 32'h0, 4'hF, 0, d, e);
    check_eq("misaligned_err", 64'(e), 64'd1);
    send(1'b0, 32'h1000, 32'h0, 4'hF, 0, d, e);
    check_eq("range_err", 64'(e), 64'd1);
    send(1'b1, 32'h42, 32'hDEADBEEF, 4'hF, 0, d, e);
    send(1'b1, 32'h1040, 32'hDEADBEEF, 4'hF, 0, d, e);
    // be=0 store is a no-op; load ignores be; hold response for 5 cycles
    send(1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 0, d, e);
    check_eq("be0_no_err", 64'(e), 64'd0);
    send(1'b0, 32'h40, 32'h0, 4'h0, 5, d, e);
    check_eq("mem_unchanged", 64'(d), 64'h12BB56DD);

    // Highest word address
    send(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 0, d, e);
    send(1'b0, 32'hFFC, 32'h0, 4'hF, 1, d, e);
    check_eq("top_addr_load", 64'(d), 64'hCAFEF00D);

    // Reset during WAIT drops an uncommitted store
    send(1'b1, 32'h80, 32'h0BADF00D, 4'hF, 0, d, e);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    check_eq("wait_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("wait_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("wait_rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("wait_rst_busy0", 64'(busy), 64'd0);
    check_eq("wait_rst_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("wait_rst_err", 64'(rsp_err), 64'd0);
    check_eq("wait_rst_req_ready", 64'(req_ready), 64'd1);
    send(1'b0, 32'h80, 32'h0, 4'hF, 0, d, e);
    check_eq("wait_rst_store_dropped", 64'(d), 64'h0BADF00D);

    // Reset during RESP keeps an already-committed store
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h84; req_wdata = 32'h5A5A5A5A; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model[33] = 32'h5A5A5A5A;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    check_eq("resp_rst_reached", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("resp_rst_valid", 64'(rsp_valid), 64'd0);
    send(1'b0, 32'h84, 32'h0, 4'hF, 0, d, e);
    check_eq("resp_rst_store_kept", 64'(d), 64'h5A5A5A5A);

    check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back latency sweep
    @(posedge clk); #1;
    s_rst = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      s_wdata = $urandom_range(32'hFFFF, 0);
    end
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("lat1_accepts", 64'(s1_acc >= 95), 64'd1);
    check_eq("lat15_accepts", 64'(s15_acc >= 12), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word-address width; the array holds 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal 1..15, SHALL set the cycles from request accept to response valid.
REQ-003 Clocking SHALL be one clock, clk_x70; reset rst_x70 is synchronous and active-high.
REQ-004 clk_x70  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_x70  in  1  synchronous active-high reset.
REQ-006 req_valid_x70  in  1  initiator presents a request.
REQ-007 req_ready_x70  out  1  responder can accept a request.
REQ-008 req_write_x70  in  1  1 = store, 0 = load.
REQ-009 req_addr_x70  in  32  byte address.
REQ-010 req_wdata_x70  in  32  store data.
REQ-011 req_be_x70  in  4  store byte enables; bit i maps to bits [8i+7:8i].
REQ-012 rsp_valid_x70  out  1  response present.
REQ-013 rsp_ready_x70  in  1  initiator takes the response.
REQ-014 rsp_rdata_x70  out  32  load data.
REQ-015 rsp_err_x70  out  1  request was misaligned or out of range.
REQ-016 busy_x70  out  1  a transaction is in flight (state not IDLE).

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-018 req_ready_x70 SHALL be 1 only in IDLE; accept = req_valid_x70 & req_ready_x70 at a rising edge.
REQ-019 On accept, the block SHALL register write, addr, wdata and be, then go to WAIT with the counter loaded to LATENCY-1; if LATENCY=1 it SHALL go directly to RESP.
REQ-020 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP; rsp_valid_x70 rises exactly LATENCY edges after the accept edge.
REQ-021 On the edge entering RESP, the block SHALL perform the array access:
  - load: rsp_rdata_x70 = mem[addr[ADDR_W+1:2]].
  - store: write only the enabled bytes; rsp_rdata_x70 = 0.
REQ-022 In RESP, rsp_valid_x70, rsp_rdata_x70 and rsp_err_x70 SHALL hold stable until rsp_ready_x70=1; on that edge the FSM goes to IDLE and rsp_valid_x70 drops.
REQ-023 A new request SHALL NOT be accepted in the cycle the response is consumed; minimum spacing between accepts is LATENCY+1 cycles.
REQ-024 The error condition SHALL be addr[1:0]!=0, or addr[31:ADDR_W+2] nonzero: rsp_err_x70=1, rsp_rdata_x70=0, no array write, full latency still observed.
REQ-025 A store with be=4'b0000 SHALL be a legal no-op: memory is unchanged and rsp_err_x70=0.
REQ-026 A load SHALL ignore be and return the full word.
REQ-027 Request inputs SHALL be ignored outside IDLE; changes after accept SHALL NOT affect the transaction.
REQ-028 A load from the highest address 2^ADDR_W-1 SHALL be legal; there is no address wrap-around.

Reset
REQ-029 With rst_x70=1 at an edge, the FSM SHALL go to IDLE with counter=0; rsp_valid_x70=0, rsp_rdata_x70=0, rsp_err_x70=0, busy_x70=0, and req_ready_x70=1 from the following cycle.
REQ-030 Reset SHALL NOT clear array contents.
REQ-031 Reset during WAIT SHALL drop the transaction and leave its store uncommitted; reset during RESP SHALL drop the response, and an already-committed store SHALL remain.
REQ-032 rst_x70 SHALL take priority over simultaneous accept or consume.

Verification
REQ-033 Store 0x12345678 at addr 0x40 with be=F, then load 0x40 (LATENCY=2) -> rsp_valid 2 edges after each accept; load returns 0x12345678, err=0.
REQ-034 Store 0xAABBCCDD at 0x40 with be=4'b0101 over 0x12345678 -> load returns 0x12BB56DD.
REQ-035 Load at 0x42, and load at 0x00001000 with ADDR_W=10 -> err=1, rdata=0, memory unchanged, latency 2.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable; req_ready=0 throughout; next accept no earlier than the cycle after consume.
REQ-037 Store 0xFFFFFFFF at 0x80 with reset asserted in WAIT -> outputs are reset values; a subsequent load at 0x80 returns the prior contents.
REQ-038 Sweep LATENCY=1 and LATENCY=15 with back-to-back requests and rsp_ready tied to 1 -> accepts spaced exactly LATENCY+1 cycles apart.
